// File: rtl/rsa_modexp_seq.sv
// Left-to-right square-and-multiply modular exponentiation sequencer (Montgomery domain).
// Drives an external Montgomery multiplier through a start/done handshake.
module rsa_modexp_seq #(
    parameter int WIDTH = 512,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_r2,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             mont_start,
    output logic [WIDTH-1:0] mont_a,
    output logic [WIDTH-1:0] mont_b,
    output logic [WIDTH-1:0] mont_m,
    input  logic             mont_done,
    input  logic [WIDTH-1:0] mont_result
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCAN   = 3'd1;
    localparam logic [2:0] S_TOMONT = 3'd2;
    localparam logic [2:0] S_SQ     = 3'd3;
    localparam logic [2:0] S_MUL    = 3'd4;
    localparam logic [2:0] S_FINAL  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic             wait_q, wait_d;
    logic             found_q, found_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] xt_q, xt_d;
    logic [WIDTH-1:0] r2_q, r2_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic op_state;
    logic op_latch;

    // xt_q holds the plain base until TOMONT overwrites it with the Montgomery-domain base.
    assign op_state = (state_q == S_TOMONT) || (state_q == S_SQ) ||
                      (state_q == S_MUL) || (state_q == S_FINAL);
    assign op_latch = op_state && wait_q && mont_done;

    assign mont_start = op_state && !wait_q;
    assign mont_m     = m_q;
    assign result     = result_q;
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        mont_a = '0;
        mont_b = '0;
        case (state_q)
            S_TOMONT: begin
                mont_a = xt_q;
                mont_b = r2_q;
            end
            S_SQ: begin
                mont_a = acc_q;
                mont_b = acc_q;
            end
            S_MUL: begin
                mont_a = acc_q;
                mont_b = xt_q;
            end
            S_FINAL: begin
                mont_a = acc_q;
                mont_b = ONE;
            end
            default: begin
                mont_a = '0;
                mont_b = '0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        found_d  = found_q;
        idx_d    = idx_q;
        e_d      = e_q;
        xt_d     = xt_q;
        r2_d     = r2_q;
        acc_d    = acc_q;
        m_d      = m_q;
        result_d = result_q;

        if (op_state && !wait_q) wait_d = 1'b1;
        if (op_latch) wait_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xt_d    = in_x;
                    e_d     = in_e;
                    m_d     = in_m;
                    acc_d   = in_r;
                    r2_d    = in_r2;
                    idx_d   = CNT_W'(WIDTH - 1);
                    found_d = 1'b0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (e_q[idx_q]) begin
                    found_d = 1'b1;
                    state_d = S_TOMONT;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else begin
                    found_d = 1'b0;
                    state_d = S_TOMONT;
                end
            end
            S_TOMONT: begin
                if (op_latch) begin
                    xt_d    = mont_result;
                    state_d = found_q ? S_SQ : S_FINAL;
                end
            end
            S_SQ: begin
                if (op_latch) begin
                    acc_d = mont_result;
                    if (e_q[idx_q]) begin
                        state_d = S_MUL;
                    end else if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                    end else begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_MUL: begin
                if (op_latch) begin
                    acc_d = mont_result;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SQ;
                    end else begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                if (op_latch) begin
                    result_d = mont_result;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            wait_q   <= 1'b0;
            found_q  <= 1'b0;
            idx_q    <= '0;
            e_q      <= '0;
            xt_q     <= '0;
            r2_q     <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            found_q  <= found_d;
            idx_q    <= idx_d;
            e_q      <= e_d;
            xt_q     <= xt_d;
            r2_q     <= r2_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            result_q <= result_d;
        end
    end

endmodule
